pattern_scan_ctrl: RTL

//   Programmable serial-pattern scan controller for the Moore sequence-detector datapath.
//   - Host loads a pattern, match target and timeout, then pulses start.
//   - Block shifts qualified din bits, flags each pattern match, counts matches and ends
//     the scan on target hit, timeout or abort.
//   - Result is held with done/status until the host acks.

---
 rtl/pattern_scan_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pattern_scan_ctrl.sv
// ============================================================================
// Module      : pattern_scan_ctrl
// Description : Programmable serial-pattern scan controller. Optional build
//               macro PATTERN_SCAN_NOOVERLAP_EN selects non-overlapping matches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_scan_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic [TMO_W-1:0] cfg_timeout,
    input  logic             start,
    input  logic             abort,
    input  logic             ack,
    input  logic             din,
    input  logic             din_valid,
    output logic             busy,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             done,
    output logic [1:0]       status
);

    localparam int FW = $clog2(PAT_W);

    localparam logic [1:0] ST_NONE  = 2'b00;
    localparam logic [1:0] ST_HIT   = 2'b01;
    localparam logic [1:0] ST_TMO   = 2'b10;
    localparam logic [1:0] ST_ABORT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_SCAN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [CNT_W-1:0]   tgt_q, tgt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [PAT_W-2:0]   shreg_q, shreg_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic [TMO_W-1:0]   bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic [1:0]         status_q, status_d;
    logic               y_q, y_d;

    logic [PAT_W-1:0]   w_win;
    logic               w_hit;
    logic [CNT_W:0]     w_mc_inc;
    logic [TMO_W:0]     w_bc_inc;

    assign w_win    = {shreg_q, din};
    assign w_hit    = (state_q == S_SCAN) && din_valid && (w_win == pat_q);
    // One extra bit so a saturated bit counter can never equal the timeout.
    assign w_mc_inc = {1'b0, match_cnt_q} + 1'b1;
    assign w_bc_inc = {1'b0, bitcnt_q} + 1'b1;

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        tgt_d       = tgt_q;
        tmo_d       = tmo_q;
        shreg_d     = shreg_q;
        fill_d      = fill_q;
        bitcnt_d    = bitcnt_q;
        match_cnt_d = match_cnt_q;
        status_d    = status_q;
        y_d         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pat_d       = cfg_pattern;
                    tgt_d       = (cfg_target == '0) ? CNT_W'(1) : cfg_target;
                    tmo_d       = cfg_timeout;
                    shreg_d     = '0;
                    fill_d      = '0;
                    bitcnt_d    = '0;
                    match_cnt_d = '0;
                    status_d    = ST_NONE;
                    state_d     = S_FILL;
                end
            end
            S_FILL, S_SCAN: begin
                if (din_valid) begin
                    shreg_d  = w_win[PAT_W-2:0];
                    bitcnt_d = (&bitcnt_q) ? bitcnt_q : bitcnt_q + 1'b1;
                    if (state_q == S_FILL) begin
                        fill_d = fill_q + 1'b1;
                        if (fill_q == FW'(PAT_W - 2))
                            state_d = S_SCAN;
                    end
                end
                if (w_hit) begin
                    y_d         = 1'b1;
                    match_cnt_d = w_mc_inc[CNT_W-1:0];
`ifdef PATTERN_SCAN_NOOVERLAP_EN
                    shreg_d     = '0;
                    fill_d      = '0;
                    state_d     = S_FILL;
`endif
                end
                // Termination overrides any FILL/SCAN transition chosen above.
                if (abort) begin
                    state_d  = S_DONE;
                    status_d = ST_ABORT;
                end else if (w_hit && (w_mc_inc == {1'b0, tgt_q})) begin
                    state_d  = S_DONE;
                    status_d = ST_HIT;
                end else if (din_valid && (tmo_q != '0) && (w_bc_inc == {1'b0, tmo_q})) begin
                    state_d  = S_DONE;
                    status_d = ST_TMO;
                end
            end
            S_DONE: begin
                if (ack)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pat_q       <= '0;
            tgt_q       <= '0;
            tmo_q       <= '0;
            shreg_q     <= '0;
            fill_q      <= '0;
            bitcnt_q    <= '0;
            match_cnt_q <= '0;
            status_q    <= ST_NONE;
            y_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            tgt_q       <= tgt_d;
            tmo_q       <= tmo_d;
            shreg_q     <= shreg_d;
            fill_q      <= fill_d;
            bitcnt_q    <= bitcnt_d;
            match_cnt_q <= match_cnt_d;
            status_q    <= status_d;
            y_q         <= y_d;
        end
    end

    assign busy      = (state_q == S_FILL) || (state_q == S_SCAN);
    assign done      = (state_q == S_DONE);
    assign y         = y_q;
    assign match_cnt = match_cnt_q;
    assign status    = status_q;

endmodule

`default_nettype wire
